// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter sharing one write-first BRAM port among NREQ requesters,
// tracking reads through the RAM latency and returning each result tagged with the requester ID.
module bram_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINED  = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NREQ-1:0]            REQ_VALID,
  input  logic [NREQ-1:0]            REQ_WRITE,
  input  logic [NREQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NREQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NREQ-1:0]            REQ_READY,
  output logic                       RSP_VALID,
  output logic [ID_WIDTH-1:0]        RSP_ID,
  output logic [DATA_WIDTH-1:0]      RSP_DATA,
  output logic                       BRAM_EN,
  output logic                       BRAM_WE,
  output logic [ADDR_WIDTH-1:0]      BRAM_ADDR,
  output logic [DATA_WIDTH-1:0]      BRAM_DI,
  input  logic [DATA_WIDTH-1:0]      BRAM_DO
);
  localparam int LW    = $clog2(NREQ);
  localparam int DEPTH = 1 + PIPELINED;
  logic [LW-1:0]       r_last;
  logic [LW-1:0]       w_gnt;
  logic                w_any;
  logic                r_vld [DEPTH];
  logic [ID_WIDTH-1:0] r_id  [DEPTH];
  // Walk from farthest to nearest so the requester closest after r_last wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (REQ_VALID[(int'(r_last) + k) % NREQ]) begin
        w_any = RST_N;
        w_gnt = LW'((int'(r_last) + k) % NREQ);
      end
    end
  end
  assign REQ_READY = w_any ? NREQ'(1) << w_gnt : '0;
  assign BRAM_EN   = w_any;
  assign BRAM_WE   = w_any & REQ_WRITE[w_gnt];
  assign BRAM_ADDR = w_any ? REQ_ADDR[w_gnt*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign BRAM_DI   = w_any ? REQ_DATA[w_gnt*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last <= LW'(NREQ - 1);
      for (int s = 0; s < DEPTH; s++) begin
        r_vld[s] <= 1'b0;
        r_id[s]  <= '0;
      end
    end else begin
      if (w_any) r_last <= w_gnt;
      r_vld[0] <= w_any & ~REQ_WRITE[w_gnt];
      r_id[0]  <= ID_WIDTH'(w_gnt);
      for (int s = 1; s < DEPTH; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
      end
    end
  end
  assign RSP_VALID = r_vld[DEPTH-1];
  assign RSP_ID    = r_id[DEPTH-1];
  assign RSP_DATA  = BRAM_DO;
endmodule
